hit_matrix: RTL and testbench
=============================

# hit_matrix

Parametrised frame-level collision detector for the game video pipeline. Compares per-pixel draw requests from all sprite/boundary objects against a configurable table of object pairs. Accumulates overlaps over each frame and issues at most one hit pulse per pair per frame at start of frame, with a per-pair frame holdoff. Sits between the object drawers and the game-state controllers (score, lives, monster direction).

## Interface
Parameters:
- NUM_OBJECTS, 6: number of draw-request inputs.
- NUM_PAIRS, 4: number of monitored object pairs.
- PAIR_A, 32'h00_02_03_02: first-object index per pair; entry p at bits [8p+7:8p].
- PAIR_B, 32'h05_04_01_01: second-object index per pair; same packing. Defaults: p0 monster1/missile, p1 monster2/missile, p2 monster1/boundary, p3 player/boundary.
- HOLDOFF_FRAMES, 0: frames suppressed after a pulse on a pair; 0 = no holdoff.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- draw_requests  in  NUM_OBJECTS  per-object draw request, current pixel.
- pair_enable  in  NUM_PAIRS  per-pair enable, sampled at startOfFrame.
- pixelX  in  11  current pixel column (coordinate capture only).
- pixelY  in  11  current pixel row (coordinate capture only).
- collision  out  NUM_PAIRS  combinational: draw_requests[PAIR_A[p]] && draw_requests[PAIR_B[p]].
- HitPulse  out  NUM_PAIRS  registered one-cycle hit pulse per pair.
- hit_any  out  1  registered OR of HitPulse, same cycle.
- hit_x  out  NUM_PAIRS*11  first-collision column per pair (capture only).
- hit_y  out  NUM_PAIRS*11  first-collision row per pair (capture only).

## Operation
- Per pair p: sticky accumulator acc[p], holdoff counter cnt[p] (width $clog2(HOLDOFF_FRAMES+1), min 1).
- Cycle without startOfFrame: acc[p] <= acc[p] | collision[p]; HitPulse <= 0; cnt unchanged.
- Cycle with startOfFrame, per pair:
  - cnt[p] != 0: HitPulse[p] <= 0, cnt[p] <= cnt[p]-1 (suppressed; holdoff decrements regardless of acc/enable).
  - else if acc[p] && pair_enable[p]: HitPulse[p] <= 1, cnt[p] <= HOLDOFF_FRAMES.
  - else: HitPulse[p] <= 0.
  - acc[p] <= collision[p] (a collision on the startOfFrame cycle belongs to the new frame).
- Pairs are independent; several pairs may pulse in the same cycle.
- Pulse on frame boundary n: boundaries n+1..n+HOLDOFF_FRAMES suppressed, n+HOLDOFF_FRAMES+1 eligible.
- PAIR_A/PAIR_B index >= NUM_OBJECTS: pair permanently inactive (collision[p] = 0); elaboration warning.
- PAIR_A[p] == PAIR_B[p] permitted: pair fires whenever that object draws.

## Timing
- Reset (async assert, any cycle): acc, cnt, HitPulse, hit_any, hit_x, hit_y all 0. Mid-frame reset discards the partial frame; first pulse earliest at the second startOfFrame after release.
- collision: zero latency, combinational.
- HitPulse/hit_any: asserted the cycle after the startOfFrame cycle, exactly one cycle wide.
- startOfFrame on consecutive cycles: each is a boundary; second sees acc = collision of first cycle only.
- Collision sampled on the cycle before startOfFrame counts in the ending frame.

## Configuration
- HIT_COORD_CAPTURE_EN defined: per pair, frame-local first_x/first_y loaded with pixelX/pixelY on the first cycle acc[p] would go 0->1 (including the startOfFrame cycle); on a pulsing boundary hit_x/hit_y[p] <= first_x/first_y, held until the next pulse of that pair. Suppressed or disabled boundaries leave hit_x/hit_y unchanged.
- Not defined: pixelX/pixelY unused; hit_x/hit_y tied to 0; no coordinate registers.

## Structure
- Package hit_pkg: COORD_W = 11, OBJ_IDX_W = 8, default pair tables and named object-index constants (OBJ_PLAYER=0, OBJ_MISSILE=1, OBJ_MONSTER1=2, OBJ_MONSTER2=3, OBJ_BOUNDARY_L=4, OBJ_BOUNDARY_R=5).
- Sub-module hit_pair_tracker: one pair's acc, holdoff counter, pulse and coordinate capture; generate-instantiated NUM_PAIRS times. Top does pair decode and hit_any.

## Test plan
- Defaults, HOLDOFF 0, enable all: draw_requests bits 1,2 high 3 cycles mid-frame -> collision[0]=1 those cycles; HitPulse=4'b0001 and hit_any=1 for one cycle after next startOfFrame.
- Overlap on startOfFrame cycle only -> no pulse at that boundary; HitPulse[0] pulses after the following startOfFrame.
- HOLDOFF_FRAMES=2, pair 0 colliding every frame -> pulses at boundaries 1,4,7; none at 2,3,5,6.
- pair_enable=4'b1110 with pairs 0 and 3 colliding -> HitPulse=4'b1000; pair 0 acc discarded.
- Reset asserted mid-frame after collision -> all outputs 0 immediately; no pulse at next startOfFrame.
- HIT_COORD_CAPTURE_EN, first overlap at (100,37), later at (120,40) -> hit_x[10:0]=100, hit_y[10:0]=37 after pulse; unchanged on a suppressed boundary.

Source files
------------

// File: rtl/hit_pkg.sv
// Shared widths, object indices and default pair tables for the hit_matrix
// collision detector.
package hit_pkg;

    localparam int unsigned COORD_W   = 11;
    localparam int unsigned OBJ_IDX_W = 8;

    localparam logic [OBJ_IDX_W-1:0] OBJ_PLAYER     = 8'd0;
    localparam logic [OBJ_IDX_W-1:0] OBJ_MISSILE    = 8'd1;
    localparam logic [OBJ_IDX_W-1:0] OBJ_MONSTER1   = 8'd2;
    localparam logic [OBJ_IDX_W-1:0] OBJ_MONSTER2   = 8'd3;
    localparam logic [OBJ_IDX_W-1:0] OBJ_BOUNDARY_L = 8'd4;
    localparam logic [OBJ_IDX_W-1:0] OBJ_BOUNDARY_R = 8'd5;

    // p0 monster1/missile, p1 monster2/missile, p2 monster1/boundary, p3 player/boundary
    localparam logic [4*OBJ_IDX_W-1:0] DEF_PAIR_A =
        {OBJ_PLAYER, OBJ_MONSTER1, OBJ_MONSTER2, OBJ_MONSTER1};
    localparam logic [4*OBJ_IDX_W-1:0] DEF_PAIR_B =
        {OBJ_BOUNDARY_R, OBJ_BOUNDARY_L, OBJ_MISSILE, OBJ_MISSILE};

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/hit_pair_tracker.sv
// One monitored pair: frame accumulator, holdoff counter and hit pulse.
// Coordinate capture is built only when HIT_COORD_CAPTURE_EN is defined.
module hit_pair_tracker
    import hit_pkg::*;
#(
    parameter int unsigned HOLDOFF_FRAMES = 0
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   sof_i,
    input  logic   coll_i,
    input  logic   en_i,
    input  coord_t px_i,
    input  coord_t py_i,
    output logic   fire_o,
    output logic   pulse_o,
    output coord_t hit_x_o,
    output coord_t hit_y_o
);

    localparam int unsigned CNT_W =
        (HOLDOFF_FRAMES == 0) ? 1 : $clog2(HOLDOFF_FRAMES + 1);
    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLDOFF_FRAMES);

    logic             acc_q, acc_d;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d  = acc_q | coll_i;
        cnt_d  = cnt_q;
        fire_o = 1'b0;
        if (sof_i) begin
            // a collision on the boundary cycle opens the new frame
            acc_d = coll_i;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else if (acc_q && en_i) begin
                fire_o = 1'b1;
                cnt_d  = HOLD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pulse_q <= fire_o;
        end
    end

    assign pulse_o = pulse_q;

`ifdef HIT_COORD_CAPTURE_EN
    coord_t first_x_q, first_y_q;
    coord_t hit_x_q, hit_y_q;
    logic   first_load;

    assign first_load = coll_i && (sof_i || !acc_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_x_q <= '0;
            first_y_q <= '0;
            hit_x_q   <= '0;
            hit_y_q   <= '0;
        end else begin
            if (first_load) begin
                first_x_q <= px_i;
                first_y_q <= py_i;
            end
            if (fire_o) begin
                hit_x_q <= first_x_q;
                hit_y_q <= first_y_q;
            end
        end
    end

    assign hit_x_o = hit_x_q;
    assign hit_y_o = hit_y_q;
`else
    logic unused_coord;
    assign unused_coord = ^{px_i, py_i};
    assign hit_x_o      = '0;
    assign hit_y_o      = '0;
`endif

endmodule

// File: rtl/hit_matrix.sv
// Frame-level collision detector over a table of object pairs.
// Optional first-hit coordinate capture: HIT_COORD_CAPTURE_EN.
module hit_matrix
    import hit_pkg::*;
#(
    parameter int unsigned NUM_OBJECTS    = 6,
    parameter int unsigned NUM_PAIRS      = 4,
    parameter logic [NUM_PAIRS*OBJ_IDX_W-1:0] PAIR_A = DEF_PAIR_A,
    parameter logic [NUM_PAIRS*OBJ_IDX_W-1:0] PAIR_B = DEF_PAIR_B,
    parameter int unsigned HOLDOFF_FRAMES = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic [NUM_OBJECTS-1:0]       draw_requests,
    input  logic [NUM_PAIRS-1:0]         pair_enable,
    input  logic [COORD_W-1:0]           pixelX,
    input  logic [COORD_W-1:0]           pixelY,
    output logic [NUM_PAIRS-1:0]         collision,
    output logic [NUM_PAIRS-1:0]         HitPulse,
    output logic                         hit_any,
    output logic [NUM_PAIRS*COORD_W-1:0] hit_x,
    output logic [NUM_PAIRS*COORD_W-1:0] hit_y
);

    logic [NUM_PAIRS-1:0] fire;
    logic                 hit_any_q;
    logic                 unused_draw;

    // objects not referenced by any pair are legitimately ignored
    assign unused_draw = ^draw_requests;

    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
        localparam int unsigned IA = 32'(PAIR_A[p*OBJ_IDX_W +: OBJ_IDX_W]);
        localparam int unsigned IB = 32'(PAIR_B[p*OBJ_IDX_W +: OBJ_IDX_W]);

        if (IA < NUM_OBJECTS && IB < NUM_OBJECTS) begin : g_valid
            assign collision[p] = draw_requests[IA] & draw_requests[IB];
        end else begin : g_inactive
            assign collision[p] = 1'b0;
            $warning("hit_matrix: pair %0d uses an out-of-range object", p);
        end

        hit_pair_tracker #(
            .HOLDOFF_FRAMES(HOLDOFF_FRAMES)
        ) u_trk (
            .clk    (clk),
            .reset  (reset),
            .sof_i  (startOfFrame),
            .coll_i (collision[p]),
            .en_i   (pair_enable[p]),
            .px_i   (pixelX),
            .py_i   (pixelY),
            .fire_o (fire[p]),
            .pulse_o(HitPulse[p]),
            .hit_x_o(hit_x[p*COORD_W +: COORD_W]),
            .hit_y_o(hit_y[p*COORD_W +: COORD_W])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_any_q <= 1'b0;
        end else begin
            hit_any_q <= |fire;
        end
    end

    assign hit_any = hit_any_q;

endmodule

// File: tb/tb_hit_matrix.sv
// Scoreboard bench for hit_matrix: a holdoff-0 and a holdoff-2 instance
// share stimulus; expected pulses are queued per frame boundary.
module tb_hit_matrix;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [5:0]  draw_requests = '0;
    logic [3:0]  pair_enable = '0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;

    logic [3:0]  coll0, hp0, coll2, hp2;
    logic        any0, any2;
    logic [43:0] hx0, hy0, hx2, hy2;

`ifdef HIT_COORD_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    typedef struct {
        logic [3:0]  p0;
        logic [3:0]  p2;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic sof_q = 1'b0;

    hit_matrix #(.HOLDOFF_FRAMES(0)) dut0 (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .draw_requests(draw_requests), .pair_enable(pair_enable),
        .pixelX(pixelX), .pixelY(pixelY), .collision(coll0),
        .HitPulse(hp0), .hit_any(any0), .hit_x(hx0), .hit_y(hy0)
    );

    hit_matrix #(.HOLDOFF_FRAMES(2)) dut2 (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .draw_requests(draw_requests), .pair_enable(pair_enable),
        .pixelX(pixelX), .pixelY(pixelY), .collision(coll2),
        .HitPulse(hp2), .hit_any(any2), .hit_x(hx2), .hit_y(hy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] cap(input int v);
        return CAP ? 11'(v) : 11'd0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) sof_q <= 1'b0;
        else       sof_q <= startOfFrame;
    end

    // monitor: a boundary's result is presented the cycle after it
    always @(negedge clk) begin
        exp_t e;
        if (sof_q) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pulse_h0", {28'd0, hp0}, {28'd0, e.p0});
                chk("any_h0", {31'd0, any0}, {31'd0, |e.p0});
                chk("pulse_h2", {28'd0, hp2}, {28'd0, e.p2});
                chk("any_h2", {31'd0, any2}, {31'd0, |e.p2});
                chk("hit_x0", {21'd0, hx0[10:0]}, {21'd0, e.x});
                chk("hit_y0", {21'd0, hy0[10:0]}, {21'd0, e.y});
            end
        end else begin
            chk("idle_h0", {27'd0, any0, hp0}, 32'd0);
            chk("idle_h2", {27'd0, any2, hp2}, 32'd0);
        end
    end

    task automatic step(input logic sof, input logic [5:0] d,
                        input logic [3:0] en, input int x, input int y,
                        input logic [3:0] ecoll);
        startOfFrame  = sof;
        draw_requests = d;
        pair_enable   = en;
        pixelX        = 11'(x);
        pixelY        = 11'(y);
        #1;
        chk("collision_h0", {28'd0, coll0}, {28'd0, ecoll});
        chk("collision_h2", {28'd0, coll2}, {28'd0, ecoll});
        @(posedge clk);
        #1;
    endtask

    task automatic boundary(input logic [5:0] d, input logic [3:0] en,
                            input int x, input int y, input logic [3:0] ecoll,
                            input logic [3:0] e0, input logic [3:0] e2,
                            input int ex, input int ey);
        exp_t e;
        e.p0 = e0;
        e.p2 = e2;
        e.x  = cap(ex);
        e.y  = cap(ey);
        sb.push_back(e);
        step(1'b1, d, en, x, y, ecoll);
    endtask

    localparam logic [5:0] D_P0   = 6'b000110;
    localparam logic [5:0] D_P03  = 6'b100111;
    localparam logic [5:0] D_P012 = 6'b011110;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pulse", {27'd0, any0, hp0}, 32'd0);
        chk("rst_hx", {20'd0, hx0[10:0], 1'b0}, 32'd0);
        reset = 1'b0;
        step(0, 0, 4'hF, 0, 0, 4'b0000);

        boundary(0, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        step(0, D_P0, 4'hF, 100, 37, 4'b0001);
        step(0, D_P0, 4'hF, 101, 37, 4'b0001);
        step(0, D_P0, 4'hF, 102, 37, 4'b0001);
        step(0, 0, 4'hF, 103, 37, 4'b0000);
        step(0, D_P0, 4'hF, 120, 40, 4'b0001);
        // B1: both pulse, holdoff-2 instance arms its counter
        boundary(0, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0001, 100, 37);
        step(0, 0, 4'hF, 1, 1, 4'b0000);
        step(0, 0, 4'hF, 2, 1, 4'b0000);
        // B2: overlap only on the boundary cycle
        boundary(D_P0, 4'hF, 200, 50, 4'b0001, 4'b0000, 4'b0000, 100, 37);
        step(0, 0, 4'hF, 3, 1, 4'b0000);
        step(0, 0, 4'hF, 4, 1, 4'b0000);
        boundary(0, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0000, 200, 50);
        // B4..B7: collide every frame; holdoff 2 fires at B4 and B7
        for (int k = 4; k <= 7; k++) begin
            step(0, D_P0, 4'hF, 10 + k, 5, 4'b0001);
            step(0, 0, 4'hF, 0, 0, 4'b0000);
            boundary(0, 4'hF, 0, 0, 4'b0000, 4'b0001,
                     (k == 4 || k == 7) ? 4'b0001 : 4'b0000, 10 + k, 5);
        end
        // B8: pair 0 disabled, pair 3 fires
        step(0, D_P03, 4'hF, 50, 50, 4'b1001);
        boundary(0, 4'b1110, 0, 0, 4'b0000, 4'b1000, 4'b1000, 17, 5);
        step(0, 0, 4'hF, 0, 0, 4'b0000);
        boundary(0, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 17, 5);
        step(0, 0, 4'hF, 0, 0, 4'b0000);
        // B10/B11 back to back
        boundary(D_P0, 4'hF, 300, 60, 4'b0001, 4'b0000, 4'b0000, 17, 5);
        boundary(0, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0001, 300, 60);
        step(0, D_P012, 4'hF, 400, 70, 4'b0111);
        boundary(D_P0, 4'hF, 500, 80, 4'b0001, 4'b0111, 4'b0110, 400, 70);
        // reset mid-frame right after the pulse is sampled
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_h0", {27'd0, any0, hp0}, 32'd0);
        chk("mid_rst_h2", {27'd0, any2, hp2}, 32'd0);
        chk("mid_rst_hx", {21'd0, hx0[10:0]}, 32'd0);
        chk("mid_rst_hy", {21'd0, hy0[10:0]}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 0, 4'hF, 0, 0, 4'b0000);
        boundary(0, 4'hF, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        step(0, D_P0, 4'hF, 600, 90, 4'b0001);
        boundary(0, 4'hF, 0, 0, 4'b0000, 4'b0001, 4'b0001, 600, 90);
        repeat (3) step(0, 0, 4'hF, 0, 0, 4'b0000);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
